retire_trace_fifo: RTL and testbench

Buffers the per-instruction retire record produced by the single-cycle core (PC, instruction, register write-back, memory access) and streams it out over a valid/ready interface to the trace consumer, such as a bench scoreboard, UART dumper or co-simulation checker. It sits directly downstream of the core's retire port and decouples a consumer that may stall from a core that retires every cycle. Records that arrive while the buffer is full are dropped and counted, never back-pressured into the core.

---
 rtl/retire_trace_fifo.sv | 149 ++++++++++++++
 tb/tb_retire_trace_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_fifo.sv
// Retire-record trace buffer: circular FIFO between the core's retire port and a stallable consumer.
// Optional feature RETIRE_TRACE_SEQ_EN adds a 32-bit retire sequence number to every stored record.
module retire_trace_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       update_i,
  input  logic [XLEN-1:0]            pc_i,
  input  logic [XLEN-1:0]            instr_i,
  input  logic [4:0]                 reg_addr_i,
  input  logic [XLEN-1:0]            reg_data_i,
  input  logic [XLEN-1:0]            mem_addr_i,
  input  logic [XLEN-1:0]            mem_data_i,
  input  logic                       flush_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [XLEN-1:0]            out_pc_o,
  output logic [XLEN-1:0]            out_instr_o,
  output logic [XLEN-1:0]            out_reg_data_o,
  output logic [XLEN-1:0]            out_mem_addr_o,
  output logic [XLEN-1:0]            out_mem_data_o,
  output logic [4:0]                 out_reg_addr_o,
  output logic [31:0]                out_seq_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [15:0]                drop_cnt_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int RW = 5 * XLEN + 5;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic [15:0]   drop_q, drop_d;
  logic          ovf_q, ovf_d;
  logic [RW-1:0] head_q, head_d;
  logic [RW-1:0] in_rec;
  logic [RW-1:0] mem_q [DEPTH];
  logic          full, pop, push, drop, head_from_in;

  assign in_rec = {pc_i, instr_i, reg_addr_i, reg_data_i, mem_addr_i, mem_data_i};

  // The head register is loaded from whichever entry sits at the next read pointer;
  // when that entry is the one being written this cycle it comes straight from the inputs.
  always_comb begin
    full   = (count_q == PW'(DEPTH));
    pop    = valid_q & out_ready_i & ~flush_i;
    push   = update_i & ~flush_i & (~full | pop);
    drop   = update_i & ~flush_i & full & ~pop;
    wptr_d = wptr_q + PW'(push);
    rptr_d = rptr_q + PW'(pop);
    drop_d = drop_q;
    if (drop && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
    ovf_d = ovf_q | drop;
    if (flush_i) begin
      wptr_d = rptr_q;
      rptr_d = rptr_q;
      drop_d = '0;
      ovf_d  = 1'b0;
    end
    count_d      = wptr_d - rptr_d;
    valid_d      = (count_d != '0);
    head_from_in = push & (rptr_d == wptr_q);
    head_d       = head_q;
    if (head_from_in) begin
      head_d = in_rec;
    end else if (valid_d) begin
      head_d = mem_q[rptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
      head_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      head_q  <= head_d;
    end
  end

  // Storage array needs no reset: only entries between the pointers are ever observed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= in_rec;
    end
  end

`ifdef RETIRE_TRACE_SEQ_EN
  logic [31:0] seq_q, seq_d;
  logic [31:0] head_seq_q, head_seq_d;
  logic [31:0] seq_mem_q [DEPTH];

  // Counts every retire strobe, dropped or not, so gaps in the stream reveal losses.
  always_comb begin
    seq_d      = seq_q + 32'(update_i);
    head_seq_d = head_seq_q;
    if (head_from_in) begin
      head_seq_d = seq_q;
    end else if (valid_d) begin
      head_seq_d = seq_mem_q[rptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      seq_q      <= '0;
      head_seq_q <= '0;
    end else begin
      seq_q      <= seq_d;
      head_seq_q <= head_seq_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      seq_mem_q[wptr_q[AW-1:0]] <= seq_q;
    end
  end

  assign out_seq_o = head_seq_q;
`else
  assign out_seq_o = '0;
`endif

  assign {out_pc_o, out_instr_o, out_reg_addr_o, out_reg_data_o, out_mem_addr_o, out_mem_data_o} = head_q;
  assign out_valid_o = valid_q;
  assign count_o     = count_q;
  assign drop_cnt_o  = drop_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_retire_trace_fifo.sv
// Self-checking bench for retire_trace_fifo: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_retire_trace_fifo;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;

  logic              clk_i = 1'b0;
  logic              rstn_i = 1'b0;
  logic              update_i = 1'b0;
  logic [XLEN-1:0]   pc_i = '0;
  logic [XLEN-1:0]   instr_i = '0;
  logic [4:0]        reg_addr_i = '0;
  logic [XLEN-1:0]   reg_data_i = '0;
  logic [XLEN-1:0]   mem_addr_i = '0;
  logic [XLEN-1:0]   mem_data_i = '0;
  logic              flush_i = 1'b0;
  logic              out_ready_i = 1'b0;
  logic              out_valid_o;
  logic [XLEN-1:0]   out_pc_o, out_instr_o, out_reg_data_o, out_mem_addr_o, out_mem_data_o;
  logic [4:0]        out_reg_addr_o;
  logic [31:0]       out_seq_o;
  logic [$clog2(DEPTH):0] count_o;
  logic [15:0]       drop_cnt_o;
  logic              overflow_o;

  int checks = 0;
  int errors = 0;
  bit compare_en = 1'b0;

  retire_trace_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .update_i(update_i), .pc_i(pc_i), .instr_i(instr_i),
    .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_pc_o(out_pc_o), .out_instr_o(out_instr_o),
    .out_reg_data_o(out_reg_data_o), .out_mem_addr_o(out_mem_addr_o),
    .out_mem_data_o(out_mem_data_o), .out_reg_addr_o(out_reg_addr_o), .out_seq_o(out_seq_o),
    .count_o(count_o), .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc, instr, rdata, maddr, mdata, seq;
    logic [4:0]  rd;
  } rec_t;

  rec_t        mq[$];
  int unsigned m_drop = 0;
  bit          m_ovf = 1'b0;
  logic [31:0] m_seq = '0;
  bit          m_pop;
  int          m_size;
  rec_t        m_rec;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of records with a DEPTH capacity limit.
  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mq.delete();
      m_drop = 0;
      m_ovf  = 1'b0;
      m_seq  = '0;
    end else begin
      m_size = mq.size();
      m_pop  = (m_size > 0) && out_ready_i;
      if (flush_i) begin
        mq.delete();
        m_drop = 0;
        m_ovf  = 1'b0;
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (update_i) begin
          if (m_size < DEPTH || m_pop) begin
            m_rec.pc = pc_i; m_rec.instr = instr_i; m_rec.rd = reg_addr_i;
            m_rec.rdata = reg_data_i; m_rec.maddr = mem_addr_i; m_rec.mdata = mem_data_i;
            m_rec.seq = m_seq;
            mq.push_back(m_rec);
          end else begin
            if (m_drop < 65535) m_drop++;
            m_ovf = 1'b1;
          end
        end
      end
      if (update_i) m_seq = m_seq + 32'd1;
    end
  end

  always @(negedge clk_i) begin
    if (compare_en) begin
      check_output("valid", 32'(out_valid_o), 32'(mq.size() > 0));
      check_output("count", 32'(count_o), 32'(mq.size()));
      check_output("drop_cnt", 32'(drop_cnt_o), m_drop);
      check_output("overflow", 32'(overflow_o), 32'(m_ovf));
      if (mq.size() > 0) begin
        check_output("head_pc", out_pc_o, mq[0].pc);
        check_output("head_instr", out_instr_o, mq[0].instr);
        check_output("head_rd", 32'(out_reg_addr_o), 32'(mq[0].rd));
        check_output("head_rdata", out_reg_data_o, mq[0].rdata);
        check_output("head_maddr", out_mem_addr_o, mq[0].maddr);
        check_output("head_mdata", out_mem_data_o, mq[0].mdata);
`ifdef RETIRE_TRACE_SEQ_EN
        check_output("head_seq", out_seq_o, mq[0].seq);
`endif
      end
`ifndef RETIRE_TRACE_SEQ_EN
      check_output("seq_tied", out_seq_o, 32'd0);
`endif
    end
  end

  // Drives one cycle of inputs at a falling edge and returns at the next falling edge.
  task automatic apply_stimulus(input logic upd, input logic rdy, input logic fl,
                                input logic [31:0] pc, input logic [31:0] instr,
                                input logic [4:0] rd, input logic [31:0] rdata,
                                input logic [31:0] maddr, input logic [31:0] mdata);
    update_i = upd; out_ready_i = rdy; flush_i = fl;
    pc_i = pc; instr_i = instr; reg_addr_i = rd; reg_data_i = rdata;
    mem_addr_i = maddr; mem_data_i = mdata;
    @(negedge clk_i);
  endtask

  task automatic apply_pc(input logic upd, input logic rdy, input logic fl, input logic [31:0] pc);
    apply_stimulus(upd, rdy, fl, pc, pc ^ 32'h13, pc[6:2], ~pc, pc + 32'h1000, pc * 3);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    compare_en = 1'b1;
    check_output("rst_valid", 32'(out_valid_o), 32'd0);
    check_output("rst_count", 32'(count_o), 32'd0);
    check_output("rst_drop", 32'(drop_cnt_o), 32'd0);
    check_output("rst_ovf", 32'(overflow_o), 32'd0);
    check_output("rst_pc", out_pc_o, 32'd0);

    apply_stimulus(1, 1, 0, 32'h10, 32'h0050_0093, 5'd1, 32'd5, 32'd0, 32'd0);
    check_output("single_valid", 32'(out_valid_o), 32'd1);
    check_output("single_pc", out_pc_o, 32'h10);
    check_output("single_instr", out_instr_o, 32'h0050_0093);
    check_output("single_rd", 32'(out_reg_addr_o), 32'd1);
    check_output("single_rdata", out_reg_data_o, 32'd5);
    apply_pc(0, 1, 0, 32'h0);
    check_output("single_count_after_pop", 32'(count_o), 32'd0);
    check_output("single_valid_after_pop", 32'(out_valid_o), 32'd0);

    for (int i = 0; i < 20; i++) apply_pc(1, 0, 0, 32'h100 + 32'(4 * i));
    check_output("fill_count", 32'(count_o), 32'd16);
    check_output("fill_drop", 32'(drop_cnt_o), 32'd4);
    check_output("fill_ovf", 32'(overflow_o), 32'd1);
    check_output("fill_head_pc", out_pc_o, 32'h100);
`ifdef RETIRE_TRACE_SEQ_EN
    check_output("fill_head_seq", out_seq_o, 32'd1);
`endif

    apply_pc(1, 1, 0, 32'h200);
    check_output("full_pp_count", 32'(count_o), 32'd16);
    check_output("full_pp_drop", 32'(drop_cnt_o), 32'd4);
    for (int k = 0; k < 16; k++) begin
      check_output("drain_pc", out_pc_o, (k < 15) ? 32'h104 + 32'(4 * k) : 32'h200);
      apply_pc(0, 1, 0, 32'h0);
    end
    check_output("drain_count", 32'(count_o), 32'd0);
    check_output("drain_ovf_sticky", 32'(overflow_o), 32'd1);

    for (int i = 0; i < 3; i++) apply_pc(1, 0, 0, 32'h300 + 32'(4 * i));
    for (int i = 0; i < 10; i++) begin
      apply_pc(0, 0, 0, 32'h0);
      check_output("hold_pc", out_pc_o, 32'h300);
      check_output("hold_count", 32'(count_o), 32'd3);
    end
    apply_pc(0, 0, 1, 32'h0);
    check_output("flush_count", 32'(count_o), 32'd0);
    check_output("flush_valid", 32'(out_valid_o), 32'd0);
    check_output("flush_ovf", 32'(overflow_o), 32'd0);
    check_output("flush_drop", 32'(drop_cnt_o), 32'd0);

    for (int i = 0; i < 41; i++) begin
      apply_pc(1, 1, 0, 32'h400 + 32'(4 * i));
      check_output("stream_count", 32'(count_o), 32'd1);
      check_output("stream_pc", out_pc_o, 32'h400 + 32'(4 * i));
    end
    apply_pc(0, 1, 0, 32'h0);
    check_output("stream_drop", 32'(drop_cnt_o), 32'd0);
    check_output("stream_count_end", 32'(count_o), 32'd0);

    for (int i = 0; i < 5; i++) apply_pc(1, 0, 0, 32'h500 + 32'(4 * i));
    check_output("pre_rst_count", 32'(count_o), 32'd5);
    update_i = 1'b0;
    @(posedge clk_i);
    #2 rstn_i = 1'b0;
    #1;
    check_output("async_rst_valid", 32'(out_valid_o), 32'd0);
    check_output("async_rst_count", 32'(count_o), 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    apply_pc(1, 1, 0, 32'h600);
    check_output("post_rst_valid", 32'(out_valid_o), 32'd1);
    check_output("post_rst_pc", out_pc_o, 32'h600);
`ifdef RETIRE_TRACE_SEQ_EN
    check_output("post_rst_seq", out_seq_o, 32'd0);
`endif
    apply_pc(0, 1, 0, 32'h0);

    compare_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
